// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach actuated signal controller. Main road (ch0) rests green,
// side roads are served round-robin on demand, and an emergency hold forces all-red.
module traffic_phase_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int TW        = 8,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  localparam int CW       = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic [NUM_CH-1:0]   req,
  input  logic                hold,
  output logic [2*NUM_CH-1:0] light,
  output logic [CW-1:0]       active_ch,
  output logic [1:0]          phase,
  output logic                sw_pulse
);
  typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, ALLRED = 2'b10} phase_t;
  phase_t              ph, ph_n;
  logic [TW-1:0]       cnt, cnt_n, cnt_inc;
  logic [CW-1:0]       ch_n, tgt, tgt_n, rr_ch;
  logic                hold_seen, hs_n, sw_n, min_ok, leave;
  logic [NUM_CH-1:0]   others;
  logic [2*NUM_CH-1:0] light_n;
  assign phase   = ph;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign min_ok  = cnt >= TW'(GREEN_MIN - 1);
  assign others  = req & ~(NUM_CH'(1) | (NUM_CH'(1) << active_ch));
  assign leave   = hold | ((active_ch == '0) ? (min_ok & |others)
                          : ((min_ok & ~req[active_ch]) | (cnt == TW'(GREEN_MAX - 1))));
  // Circular search from the channel after the current one; ch0 is the fallback target.
  always_comb begin
    rr_ch = '0;
    for (int i = NUM_CH - 1; i >= 1; i--)
      if (((int'(active_ch) + i) % NUM_CH) != 0 && req[(int'(active_ch) + i) % NUM_CH])
        rr_ch = CW'((int'(active_ch) + i) % NUM_CH);
  end
  always_comb begin
    ph_n  = ph;
    cnt_n = cnt_inc;
    ch_n  = active_ch;
    tgt_n = tgt;
    hs_n  = hold_seen;
    sw_n  = 1'b0;
    case (ph)
      GREEN: if (leave) begin
        ph_n  = YELLOW;
        cnt_n = '0;
        tgt_n = (hold | hold_seen) ? '0 : rr_ch;
        hs_n  = hold_seen | hold;
      end
      YELLOW: if (cnt == TW'(YELLOW_T - 1)) begin
        ph_n  = ALLRED;
        cnt_n = '0;
        ch_n  = hold_seen ? '0 : tgt;
      end
      ALLRED: if (hold) begin
        cnt_n = '0;
        hs_n  = 1'b1;
        tgt_n = '0;
        ch_n  = '0;
      end else if (cnt == TW'(ALLRED_T - 1)) begin
        ph_n  = GREEN;
        cnt_n = '0;
        sw_n  = 1'b1;
        hs_n  = 1'b0;
      end
      default: begin
        ph_n  = GREEN;
        cnt_n = '0;
        ch_n  = '0;
      end
    endcase
    light_n = '0;
    if (ph_n == GREEN) light_n[2*ch_n +: 2] = 2'b10;
    else if (ph_n == YELLOW) light_n[2*ch_n +: 2] = 2'b01;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ph        <= GREEN;
      cnt       <= '0;
      active_ch <= '0;
      tgt       <= '0;
      hold_seen <= 1'b0;
      sw_pulse  <= 1'b0;
      light     <= (2*NUM_CH)'(2'b10);
    end else begin
      ph        <= ph_n;
      cnt       <= cnt_n;
      active_ch <= ch_n;
      tgt       <= tgt_n;
      hold_seen <= hs_n;
      sw_pulse  <= sw_n;
      light     <= light_n;
    end
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed scenarios plus randomized run against a phase-level model.
module tb_traffic_phase_ctrl;
  localparam int N = 4, GMIN = 8, GMAX = 20, YT = 3, ART = 2, SAT = 255;
  logic       clk = 0, clear_n = 0, hold = 0;
  logic [3:0] req = '0;
  logic [7:0] light;
  logic [1:0] active_ch, phase;
  logic       sw_pulse;
  int passed = 0, total = 0;
  int m_ph, m_ch, m_cnt, m_tgt;
  bit m_hs, m_sw;

  traffic_phase_ctrl dut (.clk(clk), .clear_n(clear_n), .req(req), .hold(hold),
    .light(light), .active_ch(active_ch), .phase(phase), .sw_pulse(sw_pulse));

  always #5 clk = ~clk;

  function automatic int next_served(logic [3:0] r, int c);
    for (int i = 1; i < N; i++)
      if ((c + i) % N != 0 && r[(c + i) % N]) return (c + i) % N;
    return 0;
  endfunction

  function automatic logic [7:0] exp_light();
    logic [7:0] l = '0;
    if (m_ph == 0) l[2*m_ch +: 2] = 2'b10;
    if (m_ph == 1) l[2*m_ch +: 2] = 2'b01;
    return l;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ch = 0; m_cnt = 0; m_tgt = 0; m_hs = 0; m_sw = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic h);
    bit demand = 0, go;
    m_sw = 0;
    if (m_ph == 0) begin
      for (int k = 1; k < N; k++) if (k != m_ch && r[k]) demand = 1;
      if (m_ch == 0) go = h || (m_cnt >= GMIN - 1 && demand);
      else go = h || (m_cnt >= GMIN - 1 && !r[m_ch]) || m_cnt == GMAX - 1;
      if (go) begin
        m_tgt = (h || m_hs) ? 0 : next_served(r, m_ch);
        m_hs = m_hs | h; m_ph = 1; m_cnt = 0;
      end else m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
    end else if (m_ph == 1) begin
      if (m_cnt == YT - 1) begin m_ph = 2; m_cnt = 0; m_ch = m_hs ? 0 : m_tgt; end
      else m_cnt++;
    end else begin
      if (h) begin m_cnt = 0; m_hs = 1; m_tgt = 0; m_ch = 0; end
      else if (m_cnt == ART - 1) begin m_ph = 0; m_cnt = 0; m_sw = 1; m_hs = 0; end
      else m_cnt++;
    end
  endtask

  task automatic step();
    model_step(req, hold);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_n = 0; req = '0; hold = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 clear_n = 1;
  endtask

  task automatic wait_green(input int ch, output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = sw_pulse && active_ch == 2'(ch);
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    req = 4'b0100;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = phase == 2'b01 && active_ch == 2'd2;
    end
    step();
    #2 clear_n = 0;
    #1;
    model_reset();
    total++; if (!ok) $display("FAIL reset_setup: ch2 yellow not reached"); else passed++;
    total++; if (light !== 8'h02) $display("FAIL reset_light: got %h expected 02", light); else passed++;
    total++; if (phase !== 2'b00) $display("FAIL reset_phase: got %0d expected 0", phase); else passed++;
    total++; if (active_ch !== 2'd0) $display("FAIL reset_ch: got %0d expected 0", active_ch); else passed++;
    total++; if (sw_pulse !== 1'b0) $display("FAIL reset_sw: got %0b expected 0", sw_pulse); else passed++;
  endtask

  task automatic test_single_request();
    int n;
    do_reset();
    req = 4'b0100;
    n = 0; while (phase == 2'b00 && active_ch == 2'd0 && n < 100) begin n++; step(); end
    total++; if (n != GMIN) $display("FAIL single_green0: got %0d cycles expected %0d", n, GMIN); else passed++;
    total++; if (light !== 8'h01) $display("FAIL single_yellow_lamp: got %h expected 01", light); else passed++;
    n = 0; while (phase == 2'b01 && n < 100) begin n++; step(); end
    total++; if (n != YT) $display("FAIL single_yellow: got %0d cycles expected %0d", n, YT); else passed++;
    total++; if (light !== 8'h00 || active_ch !== 2'd2) $display("FAIL single_allred: got light %h ch %0d expected 00 ch 2", light, active_ch); else passed++;
    n = 0; while (phase == 2'b10 && n < 100) begin n++; step(); end
    total++; if (n != ART) $display("FAIL single_allred_len: got %0d expected %0d", n, ART); else passed++;
    total++; if (light !== 8'h20 || active_ch !== 2'd2 || sw_pulse !== 1'b1) $display("FAIL single_green2: got light %h ch %0d sw %0b expected 20 2 1", light, active_ch, sw_pulse); else passed++;
    step();
    total++; if (sw_pulse !== 1'b0) $display("FAIL single_pulse_len: got %0b expected 0", sw_pulse); else passed++;
  endtask

  task automatic test_gap_max();
    int n;
    bit ok;
    repeat (10) step();
    req = 4'b0000;
    step();
    total++; if (phase !== 2'b01 || active_ch !== 2'd2) $display("FAIL gap_out: got phase %0d ch %0d expected 1 2", phase, active_ch); else passed++;
    wait_green(0, ok);
    req = 4'b0100;
    wait_green(2, ok);
    n = 0; while (ok && phase == 2'b00 && n < 100) begin n++; step(); end
    req = 4'b0000;
    total++; if (n != GMAX) $display("FAIL max_out: got %0d green cycles expected %0d", n, GMAX); else passed++;
    n = 0; while (phase != 2'b00 && n < 100) begin n++; step(); end
    total++; if (active_ch !== 2'd0 || light !== 8'h02) $display("FAIL max_out_return: got ch %0d light %h expected 0 02", active_ch, light); else passed++;
  endtask

  task automatic test_round_robin();
    bit ok, zero_seen;
    int got[3];
    do_reset();
    req = 4'b0100;
    wait_green(2, ok);
    req = 4'b1110;
    zero_seen = 0;
    for (int s = 0; s < 3; s++) begin
      got[s] = -1;
      for (int i = 0; i < 300 && got[s] < 0; i++) begin
        step();
        if (phase == 2'b00 && active_ch == 2'd0) zero_seen = 1;
        if (sw_pulse) got[s] = int'(active_ch);
      end
    end
    total++; if (got[0] != 3) $display("FAIL rr_first: got %0d expected 3", got[0]); else passed++;
    total++; if (got[1] != 1) $display("FAIL rr_second: got %0d expected 1", got[1]); else passed++;
    total++; if (got[2] != 2) $display("FAIL rr_third: got %0d expected 2", got[2]); else passed++;
    total++; if (zero_seen) $display("FAIL rr_no_main: got ch0 green expected none"); else passed++;
  endtask

  task automatic test_hold();
    bit ok, left;
    int n;
    do_reset();
    req = 4'b0010;
    wait_green(1, ok);
    req = 4'b0000;
    repeat (2) step();
    hold = 1;
    step();
    total++; if (phase !== 2'b01 || active_ch !== 2'd1) $display("FAIL hold_yellow: got phase %0d ch %0d expected 1 1", phase, active_ch); else passed++;
    repeat (YT) step();
    req = 4'b1000;
    left = 0;
    repeat (10) begin step(); if (phase != 2'b10) left = 1; end
    total++; if (left || light !== 8'h00) $display("FAIL hold_allred: got left=%0b light %h expected held all-red", left, light); else passed++;
    hold = 0;
    n = 0; while (phase == 2'b10 && n < 50) begin n++; step(); end
    total++; if (n != ART) $display("FAIL hold_release: got %0d cycles expected %0d", n, ART); else passed++;
    total++; if (active_ch !== 2'd0 || light !== 8'h02 || sw_pulse !== 1'b1) $display("FAIL hold_main: got ch %0d light %h sw %0b expected 0 02 1", active_ch, light, sw_pulse); else passed++;
  endtask

  task automatic test_idle();
    int pulses = 0, off = 0;
    do_reset();
    repeat (500) begin step(); pulses += sw_pulse; if (phase != 2'b00 || light != 8'h02) off++; end
    total++; if (off != 0 || pulses != 0) $display("FAIL idle_rest: got %0d off-green %0d pulses expected 0 0", off, pulses); else passed++;
    req = 4'b0010;
    step();
    total++; if (phase !== 2'b01 || active_ch !== 2'd0) $display("FAIL idle_leave: got phase %0d ch %0d expected 1 0", phase, active_ch); else passed++;
  endtask

  task automatic test_random();
    int bad = 0, lit;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if (hold) hold = $urandom_range(0, 9) != 0;
      else hold = $urandom_range(0, 199) == 0;
      step();
      lit = 0;
      for (int c = 0; c < N; c++) if (light[2*c +: 2] != 2'b00) lit++;
      total++;
      if (light !== exp_light() || active_ch !== 2'(m_ch) || phase !== 2'(m_ph) || sw_pulse !== m_sw || lit > 1) begin
        bad++;
        if (bad <= 10) $display("FAIL random_cycle %0d: got light %h ch %0d ph %0d sw %0b expected %h %0d %0d %0b",
          i, light, active_ch, phase, sw_pulse, exp_light(), m_ch, m_ph, m_sw);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_gap_max();
    test_round_robin();
    test_hold();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
